// File: rtl/seg_timing_pkg.sv
// Shared widths, default prescaler compare and the switch-to-compare mapping
// for the seven-segment seconds timebase.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
package seg_timing_pkg;

  localparam int unsigned COUNT_W = 24;
  localparam int unsigned DIGIT_W = 4;

  // One second at the 10 MHz system clock.
  localparam logic [COUNT_W-1:0] MAX_COUNT_DEFAULT = 24'd10_000_000;

  // Zero on the switches selects the default; otherwise each switch step is
  // 1024 cycles, so the smallest programmable period is 1024.
  function automatic logic [COUNT_W-1:0] compare_of(
    input logic [7:0]         sel,
    input logic [COUNT_W-1:0] dflt
  );
    return (sel == 8'd0) ? dflt : {6'b0, sel, 10'b0};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: counts enabled cycles up to a programmable compare, emits a 1-cycle tick.
// Latency: first tick is registered on the compare-th enabled edge after reset/clear.
// Backpressure: none; ena low freezes the count and suppresses tick.
//
// Ports:
//   clk, reset (sync, active-high), ena (count enable), clear (sync clear)
//   compare [COUNT_W]  period in cycles (must be nonzero)
//   tick               registered one-cycle pulse on terminal count
//   count   [COUNT_W]  current prescaler value
module tick_prescaler
  import seg_timing_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               clear,
  input  logic [COUNT_W-1:0] compare,
  output logic               tick,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_q, count_d;
  logic               tick_q,  tick_d;
  logic               terminal;

  // >= rather than == so that lowering compare below the current count ends
  // the period on the next enabled edge instead of rolling through 2^24.
  assign terminal = (count_q >= (compare - COUNT_W'(1)));

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (ena) begin
      if (terminal) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick  = tick_q;
  assign count = count_q;

endmodule

// File: rtl/digit_timebase.sv
// Timebase and digit counter feeding the seg7 decoder: advances a digit once per prescaler period.
// Latency: digit, tick and wrap update on the same edge; first tick after compare enabled edges.
// Backpressure: none; ena low freezes prescaler and digit and holds tick/wrap low.
//
// Ports:
//   clk, reset (sync, active-high), ena, clear (sync digit+prescaler clear)
//   compare_sel [8]  switch value, 0 selects MAX_COUNT, else sel*1024
//   digit [4]        current digit, tick/wrap one-cycle pulses, count_low = prescaler[7:0]
// Build option: define DIGIT_HEX_EN for a 0..15 hex digit (DIGIT_MAX unused then).
module digit_timebase
  import seg_timing_pkg::*;
#(
  parameter logic [COUNT_W-1:0] MAX_COUNT = MAX_COUNT_DEFAULT,
  parameter logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               clear,
  input  logic [7:0]         compare_sel,
  output logic [DIGIT_W-1:0] digit,
  output logic               tick,
  output logic               wrap,
  output logic [7:0]         count_low
);

  logic [COUNT_W-1:0] compare;
  logic [COUNT_W-1:0] count;
  logic               advance;
  logic               last_digit;

  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               wrap_q,  wrap_d;

  assign compare = compare_of(compare_sel, MAX_COUNT);

  tick_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .ena     (ena),
    .clear   (clear),
    .compare (compare),
    .tick    (tick),
    .count   (count)
  );

  // Same terminal test as the prescaler, evaluated here so the digit moves on
  // the very edge that registers tick.
  assign advance = ena && !clear && (count >= (compare - COUNT_W'(1)));

`ifdef DIGIT_HEX_EN
  assign last_digit = (digit_q == {DIGIT_W{1'b1}});
`else
  // >= so an out-of-range digit still returns to 0 on the next tick.
  assign last_digit = (digit_q >= DIGIT_MAX);
`endif

  always_comb begin
    digit_d = digit_q;
    wrap_d  = 1'b0;
    if (clear) begin
      digit_d = '0;
    end else if (advance) begin
      if (last_digit) begin
        digit_d = '0;
        wrap_d  = 1'b1;
      end else begin
        digit_d = digit_q + DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      wrap_q  <= wrap_d;
    end
  end

  assign digit     = digit_q;
  assign wrap      = wrap_q;
  assign count_low = count[7:0];

endmodule

// File: tb/tb_digit_timebase.sv
// Self-checking bench for digit_timebase: directed scenarios with literal
// expectations plus a randomized phase, all outputs compared every cycle
// against an arithmetic model of the timebase.
module tb_digit_timebase;

  localparam int DEF_CMP = 50;
`ifdef DIGIT_HEX_EN
  localparam int DMOD = 16;
`else
  localparam int DMOD = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] compare_sel = 8'd1;
  logic [3:0] digit;
  logic       tick;
  logic       wrap;
  logic [7:0] count_low;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: prescaler value, digit, last tick/wrap.
  int m_p = 0;
  int m_d = 0;
  int m_t = 0;
  int m_w = 0;

  always #50 clk = ~clk;

  digit_timebase #(.MAX_COUNT(24'd50), .DIGIT_MAX(4'd9)) dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .clear       (clear),
    .compare_sel (compare_sel),
    .digit       (digit),
    .tick        (tick),
    .wrap        (wrap),
    .count_low   (count_low)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Period in cycles the switches currently request.
  function automatic int period_of(input int sel);
    return (sel == 0) ? DEF_CMP : sel * 1024;
  endfunction

  always @(posedge clk) begin
    int cmp;
    cmp = period_of(int'(compare_sel));
    if (reset || clear) begin
      m_p = 0; m_d = 0; m_t = 0; m_w = 0;
    end else if (!ena) begin
      m_t = 0; m_w = 0;
    end else if (m_p >= cmp - 1) begin
      m_p = 0;
      m_t = 1;
      m_w = (m_d >= DMOD - 1) ? 1 : 0;
      m_d = (m_d >= DMOD - 1) ? 0 : m_d + 1;
    end else begin
      m_p = m_p + 1;
      m_t = 0; m_w = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_digit", int'(digit), m_d);
      check("model_tick", int'(tick), m_t);
      check("model_wrap", int'(wrap), m_w);
      check("model_count_low", int'(count_low), m_p % 256);
    end
  end

  // Advance until tick is seen; n = enabled-or-not edges consumed.
  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < maxc);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int tot;
    int frozen;

    // Reset held three cycles with ena high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_digit", int'(digit), 0);
      check("reset_tick", int'(tick), 0);
      check("reset_wrap", int'(wrap), 0);
      check("reset_count_low", int'(count_low), 0);
    end
    reset = 1'b0;

    // Programmed period of 1024 cycles.
    tot = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_tick(2000, n);
      tot += n;
      check("tick_cycle", tot, 1024 * k);
      check("tick_digit", int'(digit), k % DMOD);
    end

    // Run to the tenth tick: decimal build wraps there.
    for (int k = 4; k <= 10; k++) begin
      wait_tick(2000, n);
      check("wrap_period", n, 1024);
      check("wrap_digit", int'(digit), k % DMOD);
      check("wrap_flag", int'(wrap), (k == 10 && DMOD == 10) ? 1 : 0);
    end

    // Freeze 500 cycles mid-period.
    repeat (300) @(negedge clk);
    ena = 1'b0;
    frozen = int'(count_low);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (i % 100 == 99) begin
        check("freeze_count", int'(count_low), frozen);
        check("freeze_tick", int'(tick), 0);
      end
    end
    ena = 1'b1;
    wait_tick(3000, n);
    check("freeze_delay", 300 + 500 + n, 1524);

    // Compare decrease mid-count ends the period on the next edge.
    compare_sel = 8'd4;
    repeat (2000) @(negedge clk);
    check("decr_count_low", int'(count_low), 2000 % 256);
    compare_sel = 8'd1;
    wait_tick(10, n);
    check("decr_next_edge", n, 1);
    wait_tick(2000, n);
    check("decr_period1", n, 1024);
    wait_tick(2000, n);
    check("decr_period2", n, 1024);

    // Clear at digit 7.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int k = 0; k < 7; k++) wait_tick(2000, n);
    check("clear_pre_digit", int'(digit), 7);
    repeat (100) @(negedge clk);
    clear = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    check("clear_digit", int'(digit), 0);
    check("clear_count", int'(count_low), 0);
    clear = 1'b0;
    ena = 1'b1;
    wait_tick(2000, n);
    check("clear_period", n, 1024);
    check("clear_next_digit", int'(digit), 1);

    // Reset with ena high and clear low.
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset2_digit", int'(digit), 0);
    check("reset2_count", int'(count_low), 0);
    check("reset2_tick", int'(tick), 0);

    // Default compare path (MAX_COUNT overridden to 50).
    reset = 1'b0;
    compare_sel = 8'd0;
    wait_tick(200, n);
    check("default_period", n, 50);
    check("default_digit", int'(digit), 1);

    // Randomized phase.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      ena   = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 499) == 0);
      reset = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 3))
          0:       compare_sel = 8'd0;
          1:       compare_sel = 8'd1;
          2:       compare_sel = 8'd2;
          default: compare_sel = 8'($urandom_range(0, 3));
        endcase
      end
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
